// File: rtl/sipo_frame_controller_if.sv
// rtl/sipo_frame_controller_if.sv - serial line and parallel word handshake bundle for sipo_frame_controller
interface sipo_frame_controller_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;

    modport master (
        input  serial_in, data_ready,
        output data_out, data_valid, busy, overrun, frame_err
    );

    modport slave (
        output serial_in, data_ready,
        input  data_out, data_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/sipo_frame_controller.sv
// rtl/sipo_frame_controller.sv - framed serial word capture into a valid/ready holding register
// Optional even-parity bit between data and stop bits is enabled by defining SIPO_FRAME_PARITY_EN.
module sipo_frame_controller #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   clear_n,
    sipo_frame_controller_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_FRAME_PARITY_EN
    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, STOP, RESYNC} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, STOP, RESYNC} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             bad_word;
`ifdef SIPO_FRAME_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        data_d      = data_q;
        valid_d     = valid_q && !bus.data_ready;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        bad_word    = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
        par_err_d   = par_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (!bus.serial_in) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d = {sr_q[WIDTH-2:0], bus.serial_in};
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_FRAME_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SIPO_FRAME_PARITY_EN
            PARITY: begin
                par_err_d = (^sr_q) ^ bus.serial_in;
                state_d   = STOP;
            end
`endif
            STOP: begin
`ifdef SIPO_FRAME_PARITY_EN
                bad_word = par_err_q || !bus.serial_in;
`else
                bad_word = !bus.serial_in;
`endif
                // A low stop bit may be the start of a stuck line, so wait for it to rise.
                state_d = bus.serial_in ? IDLE : RESYNC;
                if (bad_word) begin
                    frame_err_d = 1'b1;
                end else if (valid_q && !bus.data_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                end
            end
            RESYNC: begin
                if (bus.serial_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef SIPO_FRAME_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: doc/sipo_frame_controller.md
# sipo_frame_controller

Receive-side controller that sequences a left-shifting serial-in/parallel-out shift register to capture framed serial words. It detects a start bit, enables shifting for exactly WIDTH data bits, checks the stop bit, and transfers the assembled word into an output holding register. A valid/ready handshake presents that register to the downstream consumer. The block sits between a one-bit-per-clock serial line and any parallel consumer of the word.

## Interface
- WIDTH, 4: data bits per frame; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial line, sampled once per rising edge; idles high.
- data_out  output  WIDTH  holding register with the last accepted word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out on a cycle where data_valid && data_ready.
- busy  output  1  high in every state except IDLE.
- overrun  output  1  one-cycle pulse: a completed word was dropped because the holding register was still full.
- frame_err  output  1  one-cycle pulse: stop bit (or parity, when enabled) check failed.

## Operation
- Frame format: start bit 0, then WIDTH data bits, then [parity bit], then stop bit 1.
- Internal shift register sr[WIDTH-1:0]: sr <= {sr[WIDTH-2:0], serial_in}. The first data bit ends up in the MSB and the last data bit in bit 0.
- Bit counter is ceil(log2(WIDTH+1)) bits wide. It counts 0..WIDTH-1 in SHIFT and has no wrap beyond that.
- FSM states: IDLE, SHIFT, PARITY (macro only), STOP, RESYNC.
- IDLE: if serial_in==0, clear the counter and go to SHIFT. Otherwise stay.
- SHIFT: shift one bit per cycle. After the WIDTH-th bit, go to PARITY if enabled, otherwise STOP.
- STOP, serial_in==1 (good frame): load sr into data_out and set data_valid, go to IDLE.
    - Exception: if data_valid is already 1 and data_ready is 0, drop the word instead, pulse overrun, leave data_out unchanged, go to IDLE.
- STOP, serial_in==0: pulse frame_err, discard the word, go to RESYNC.
- RESYNC: stay until serial_in==1, then go to IDLE. This prevents a stuck-low line from being read as back-to-back start bits.
- Handshake: data_valid clears on the cycle after data_valid && data_ready, unless a new word loads on that same edge.
    - Load and accept on the same edge: data_out takes the new word, data_valid stays 1, no overrun.
- Reset, including mid-frame: state IDLE, counter 0, sr 0, data_out 0, data_valid 0, busy 0, overrun 0, frame_err 0.

## Timing
- Start bit sampled at edge t, data bits sampled at edges t+1..t+WIDTH, stop bit at edge t+WIDTH+1.
- data_valid is first high after edge t+WIDTH+1, i.e. latency WIDTH+2 edges from start bit. With parity, stop is at t+WIDTH+2 and latency is WIDTH+3.
- overrun and frame_err are high for exactly the one cycle following the STOP edge.
- busy is high from the edge after the start bit is sampled until the return to IDLE.
- A new start bit can be accepted on the edge immediately after a good STOP edge, giving back-to-back frames with no idle gap.
- data_ready has no combinational path to any output; all outputs are registered.

## Configuration
- SIPO_FRAME_PARITY_EN defined:
    - Adds the PARITY state, which samples one bit after the data bits.
    - Even parity: the XOR of the data bits and the parity bit must be 0.
    - On mismatch the word is discarded and frame_err pulses on the STOP edge, whatever the stop bit value. The FSM goes to IDLE if the stop bit was 1, otherwise to RESYNC.
- SIPO_FRAME_PARITY_EN undefined: no PARITY state and no parity logic; the frame is start + WIDTH + stop.

## Test plan
- Reset mid-SHIFT (drive clear_n low for 1 ns between edges): all outputs are immediately 0, and the next frame decodes correctly.
- WIDTH=4, data_ready=1, serial_in 0,1,0,1,1,1 (start, data, stop): data_out=4'b1011, data_valid high for one cycle, 6 edges after the start bit.
- Two back-to-back frames carrying 1011 then 0110 with data_ready=0: first word held in data_out, overrun pulses once, data_out stays 4'b1011.
- Stop bit 0, then serial_in held 0 for 5 cycles, then 1: frame_err pulses once, no data_valid, busy stays high until serial_in returns to 1.
- data_ready asserted on the same edge a new word loads: data_valid stays 1, data_out updates to the new word, no overrun.
- With SIPO_FRAME_PARITY_EN, data 1011 sent with parity 0 (wrong; correct is 1): frame_err pulses, data_valid stays 0. The same frame with parity 1 yields data_out=4'b1011.
